mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit between the EX/MEM pipeline register and the word-wide data RAM.
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into RAM word accesses, with read-modify-write merging for sub-word stores.
- Splits accesses that cross a word boundary into two RAM cycles and stalls the pipeline for one cycle while it does so.
- Produces a registered MEM/WB load result.

Parameters:
- DATA_SIZE, 32, RAM word width; fixed at 32 for this block.
- SELEC_SIZE, 16, RAM word-index width; the byte address is SELEC_SIZE+2 bits.
- ADDRESSES, 65536, RAM depth in words; word index wraps modulo ADDRESSES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  a memory operation is present this cycle
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as a no-op
- req_unsigned  in  1  zero-extend loads (LBU/LHU); 0 = sign-extend
- req_addr  in  SELEC_SIZE+2  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  load destination register
- stall  out  1  hold the EX/MEM register and all upstream stages
- wb_valid  out  1  registered: load result valid
- wb_rd  out  5  registered destination register
- wb_data  out  32  registered, extended load data
- dm_we  out  1  RAM write enable
- dm_address  out  SELEC_SIZE  RAM word index
- dm_d  out  32  RAM write data
- dm_q  in  32  RAM combinational read data

Behaviour:
- Memory layout is little-endian. Byte offset is off=req_addr[1:0]; word index is W=req_addr[SELEC_SIZE+1:2]. Access length n = 1, 2 or 4 bytes.
- Split condition: off+n>4. This covers a half at off=3 and a word at off=1..3.
- FSM states are IDLE and SECOND. Reset puts the FSM in IDLE and clears wb_valid, wb_rd and wb_data to 0.
- IDLE, non-split access (single cycle):
  - dm_address=W.
  - Store: dm_d = dm_q with bytes off..off+n-1 replaced by the low n bytes of req_wdata; dm_we=1. The RAM writes at the next edge.
  - Load: bytes are extracted from dm_q and extended per req_unsigned. At the next edge wb_valid=1, wb_rd=req_rd, wb_data=result.
  - stall=0.
- IDLE, split access:
  - stall=1 combinationally. dm_address=W.
  - Bytes off..3 come from word W: a store merges and writes them (dm_we=1); a load captures them into a holding register.
  - Latch the request and the count of remaining bytes. Go to SECOND. wb_valid=0 at the next edge.
- SECOND:
  - req_* inputs are ignored; latched values are used. dm_address=(W+1) mod ADDRESSES.
  - Store: the remaining low bytes of word W+1 are merged and written.
  - Load: the holding bytes (low) are combined with bytes from W+1 (high), then extended. wb is registered at the next edge.
  - stall=0. Return to IDLE.
- Stores and no-ops (req_valid=0 or req_size=3) register wb_valid=0. dm_we=0 when there is no valid store.
- wb_valid is set even when rd=0; write-back discards it.
- While rst_n=0: dm_we=0 and stall=0.
- Reset asserted in SECOND aborts the access. For a split store, the word W write has already happened and the W+1 write is dropped.
- Back-to-back single-cycle requests sustain one access per cycle with no bubbles.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output addr_err (1 bit), registered and reset to 0.
  - A split-condition request, or any access with off not a multiple of n, is not executed: dm_we=0 and wb_valid=0.
  - addr_err=1 for one cycle after the edge. No stall is raised and SECOND is never entered.
- Undefined: no addr_err port. Misaligned accesses are split as described above. Non-crossing misaligned accesses (e.g. a half at off=1) complete in one cycle.

Test Plan:
- RAM word 0x10 (byte 0x40) = 0x8899AABB. LB at 0x41 -> wb_data=0xFFFFFFAA. LBU at 0x41 -> 0x000000AA. Both have wb_valid one cycle after the request, stall=0.
- SH 0x1234 to 0x42 over word 0x8899AABB -> word 0x10 becomes 0x1234AABB, dm_we high exactly one cycle.
- Words 0x10=0x44332211 and 0x11=0x88776655. LW at 0x43 -> stall high one cycle, RAM index 0x10 then 0x11, wb_data=0x77665544 registered after the second cycle.
- SW 0xDEADBEEF to 0x42 -> word 0x10 upper half = 0xBEEF and word 0x11 lower half = 0xDEAD. Other bytes are unchanged, two dm_we pulses.
- Split LH at byte address 0x3FFFF (W=0xFFFF) -> second access at index 0x0000 (wrap); the result combines byte 0x3FFFF (low) with byte 0x00000 (high).
- Reset pulse during SECOND of a split SW -> only word W is modified, wb_valid=0 and FSM in IDLE after release. With MISALIGN_TRAP_EN, an LW at 0x43 -> addr_err=1, no write, wb_valid=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-addressed loads/stores onto a word RAM, with
// split handling of word-crossing accesses. Optional macro MISALIGN_TRAP_EN traps misalignment.
module mem_stage_lsu #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 16,
    parameter int ADDRESSES  = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [SELEC_SIZE+1:0] req_addr,
    input  logic [DATA_SIZE-1:0]  req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_SIZE-1:0]  wb_data,
    output logic                  dm_we,
    output logic [SELEC_SIZE-1:0] dm_address,
    output logic [DATA_SIZE-1:0]  dm_d,
    input  logic [DATA_SIZE-1:0]  dm_q
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                  addr_err
`endif
);

    typedef enum logic {StIdle, StSecond} state_e;

    typedef struct packed {
        logic                  we;
        logic                  uns;
        logic [1:0]            size;
        logic [1:0]            off;
        logic [SELEC_SIZE-1:0] w;
        logic [31:0]           wdata;
        logic [4:0]            rd;
    } req_t;

    state_e                state_q, state_d;
    req_t                  req_q, req_d, cur;
    logic [31:0]           hold_q, hold_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic [3:0]            nmask;
    logic [2:0]            len;
    logic                  split;
    logic [4:0]            sh;
    logic [63:0]           wr_lanes;
    logic [7:0]            be_lanes;
    logic [63:0]           ld_pair;
    logic [31:0]           ld_raw;
    logic [SELEC_SIZE-1:0] w_next;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'd0:    return uns ? {24'b0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'd1:    return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // In SECOND the live request is ignored; everything comes from the latched copy.
    always_comb begin
        if (state_q == StSecond) begin
            cur = req_q;
        end else begin
            cur = '{we: req_we, uns: req_unsigned, size: req_size, off: req_addr[1:0],
                    w: req_addr[SELEC_SIZE+1:2], wdata: req_wdata, rd: req_rd};
        end
    end

    always_comb begin
        nmask = 4'b1111;
        len   = 3'd4;
        case (cur.size)
            2'd0:    begin nmask = 4'b0001; len = 3'd1; end
            2'd1:    begin nmask = 4'b0011; len = 3'd2; end
            default: ;
        endcase
    end

    // Word-pair lanes: low half addresses word W, high half word W+1.
    assign split    = ({1'b0, cur.off} + len) > 3'd4;
    assign sh       = {cur.off, 3'b000};
    assign wr_lanes = {32'b0, cur.wdata} << sh;
    assign be_lanes = {4'b0, nmask} << cur.off;
    assign ld_pair  = (state_q == StSecond) ? {dm_q, hold_q} : {32'b0, dm_q};
    assign ld_raw   = 32'(ld_pair >> sh);
    assign w_next   = (req_q.w == SELEC_SIZE'(ADDRESSES - 1)) ? '0 : req_q.w + 1'b1;

`ifdef MISALIGN_TRAP_EN
    logic addr_err_q, addr_err_d;
    logic misal;
    assign misal    = (cur.size == 2'd1 && cur.off[0]) || (cur.size == 2'd2 && cur.off != 2'd0);
    assign addr_err = addr_err_q;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        hold_d     = hold_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        stall      = 1'b0;
        dm_we      = 1'b0;
        dm_address = cur.w;
        dm_d       = merge(dm_q, wr_lanes[31:0], be_lanes[3:0]);
`ifdef MISALIGN_TRAP_EN
        addr_err_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid && req_size != 2'd3) begin
`ifdef MISALIGN_TRAP_EN
                    if (misal) begin
                        addr_err_d = 1'b1;
                    end else
`endif
                    if (split) begin
                        stall   = 1'b1;
                        dm_we   = cur.we;
                        req_d   = cur;
                        hold_d  = dm_q;
                        state_d = StSecond;
                    end else begin
                        dm_we = cur.we;
                        if (!cur.we) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = cur.rd;
                            wb_data_d  = extend(ld_raw, cur.size, cur.uns);
                        end
                    end
                end
            end
            StSecond: begin
                dm_address = w_next;
                dm_d       = merge(dm_q, wr_lanes[63:32], be_lanes[7:4]);
                dm_we      = cur.we;
                if (!cur.we) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = cur.rd;
                    wb_data_d  = extend(ld_raw, cur.size, cur.uns);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!rst_n) begin
            dm_we = 1'b0;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= '0;
            hold_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            hold_q     <= hold_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
`ifdef MISALIGN_TRAP_EN
            addr_err_q <= addr_err_d;
`endif
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu against a behavioural word RAM.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [17:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        stall, wb_valid, dm_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, dm_d, dm_q;
    logic [15:0] dm_address;
`ifdef MISALIGN_TRAP_EN
    logic        addr_err;
`endif

    logic [31:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .dm_we(dm_we), .dm_address(dm_address),
        .dm_d(dm_d), .dm_q(dm_q)
`ifdef MISALIGN_TRAP_EN
        , .addr_err(addr_err)
`endif
    );

    always #5 clk = ~clk;

    assign dm_q = mem[dm_address];
    always @(posedge clk) if (dm_we) mem[dm_address] <= dm_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [17:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
        mem[16] <= 32'h8899AABB;
        @(negedge clk);
        rst_n = 1'b1;

        // LB / LBU at 0x41
        drive(1'b0, 2'd0, 1'b0, 18'h41, 32'h0, 5'd3);
        chk("lb_stall", {31'b0, stall}, 32'd0);
        chk("lb_addr", {16'b0, dm_address}, 32'h10);
        tick();
        chk("lb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_rd", {27'b0, wb_rd}, 32'd3);
        chk("lb_data", wb_data, 32'hFFFFFFAA);
        drive(1'b0, 2'd0, 1'b1, 18'h41, 32'h0, 5'd4);
        tick();
        chk("lbu_valid", {31'b0, wb_valid}, 32'd1);
        chk("lbu_data", wb_data, 32'h000000AA);

        // SH 0x1234 at 0x42
        drive(1'b1, 2'd1, 1'b0, 18'h42, 32'h0000_1234, 5'd0);
        chk("sh_we", {31'b0, dm_we}, 32'd1);
        chk("sh_stall", {31'b0, stall}, 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("sh_we_off", {31'b0, dm_we}, 32'd0);
        chk("sh_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("sh_word", mem[16], 32'h1234AABB);

`ifndef MISALIGN_TRAP_EN
        mem[16] <= 32'h44332211;
        mem[17] <= 32'h88776655;

        // Non-crossing misaligned half completes in one cycle
        drive(1'b0, 2'd1, 1'b1, 18'h41, 32'h0, 5'd5);
        chk("lhu_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("lhu_data", wb_data, 32'h00003322);

        // Split LW at 0x43
        drive(1'b0, 2'd2, 1'b0, 18'h43, 32'h0, 5'd7);
        chk("lw_stall1", {31'b0, stall}, 32'd1);
        chk("lw_addr1", {16'b0, dm_address}, 32'h10);
        tick();
        req_valid = 1'b0;
        #1;
        chk("lw_stall2", {31'b0, stall}, 32'd0);
        chk("lw_addr2", {16'b0, dm_address}, 32'h11);
        chk("lw_mid_valid", {31'b0, wb_valid}, 32'd0);
        tick();
        chk("lw_valid", {31'b0, wb_valid}, 32'd1);
        chk("lw_rd", {27'b0, wb_rd}, 32'd7);
        chk("lw_data", wb_data, 32'h77665544);

        // Split SW at 0x42
        drive(1'b1, 2'd2, 1'b0, 18'h42, 32'hDEADBEEF, 5'd0);
        chk("sw_we1", {31'b0, dm_we}, 32'd1);
        chk("sw_stall1", {31'b0, stall}, 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("sw_we2", {31'b0, dm_we}, 32'd1);
        chk("sw_addr2", {16'b0, dm_address}, 32'h11);
        tick();
        chk("sw_we3", {31'b0, dm_we}, 32'd0);
        chk("sw_word0", mem[16], 32'hBEEF2211);
        chk("sw_word1", mem[17], 32'h8877DEAD);

        // Split LH wrapping from word 0xFFFF to word 0
        mem[65535] <= 32'h80112233;
        mem[0]     <= 32'h445566F0;
        drive(1'b0, 2'd1, 1'b0, 18'h3FFFF, 32'h0, 5'd9);
        chk("wrap_stall", {31'b0, stall}, 32'd1);
        chk("wrap_addr1", {16'b0, dm_address}, 32'hFFFF);
        tick();
        req_valid = 1'b0;
        #1;
        chk("wrap_addr2", {16'b0, dm_address}, 32'h0000);
        tick();
        chk("wrap_valid", {31'b0, wb_valid}, 32'd1);
        chk("wrap_data", wb_data, 32'hFFFFF080);

        // Reset during SECOND of a split SW
        mem[16] <= 32'h11111111;
        mem[17] <= 32'h22222222;
        drive(1'b1, 2'd2, 1'b0, 18'h43, 32'hAABBCCDD, 5'd0);
        chk("rs_we1", {31'b0, dm_we}, 32'd1);
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rs_we_in_rst", {31'b0, dm_we}, 32'd0);
        chk("rs_stall_in_rst", {31'b0, stall}, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rs_word0", mem[16], 32'hDD111111);
        chk("rs_word1", mem[17], 32'h22222222);

        // Back-to-back single-cycle loads, FSM back in IDLE
        drive(1'b0, 2'd0, 1'b1, 18'h44, 32'h0, 5'd1);
        chk("b2b_stall1", {31'b0, stall}, 32'd0);
        tick();
        chk("b2b_data1", wb_data, 32'h00000022);
        drive(1'b0, 2'd2, 1'b0, 18'h40, 32'h0, 5'd2);
        chk("b2b_stall2", {31'b0, stall}, 32'd0);
        tick();
        chk("b2b_valid2", {31'b0, wb_valid}, 32'd1);
        chk("b2b_rd2", {27'b0, wb_rd}, 32'd2);
        chk("b2b_data2", wb_data, 32'hDD111111);
        req_valid = 1'b0;
`else
        mem[16] <= 32'h44332211;
        mem[17] <= 32'h88776655;
        drive(1'b0, 2'd2, 1'b0, 18'h43, 32'h0, 5'd7);
        chk("trap_stall", {31'b0, stall}, 32'd0);
        chk("trap_we", {31'b0, dm_we}, 32'd0);
        tick();
        chk("trap_err", {31'b0, addr_err}, 32'd1);
        chk("trap_wb_valid", {31'b0, wb_valid}, 32'd0);
        drive(1'b1, 2'd1, 1'b0, 18'h41, 32'hFFFF, 5'd0);
        chk("trap_sh_we", {31'b0, dm_we}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("trap_sh_err", {31'b0, addr_err}, 32'd1);
        chk("trap_word", mem[16], 32'h44332211);
        tick();
        chk("trap_err_clear", {31'b0, addr_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
